// File: rtl/ysyx_25040101_exu_seq.sv
// Multi-cycle execute sequencer: steers the shared ALU over one or two
// cycles per instruction and hands writeback/redirect results to the WBU.
module ysyx_25040101_exu_seq (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  cls_i,
  input  logic [3:0]  aluop_i,
  output logic [1:0]  srca_ctrl_o,
  output logic [2:0]  srcb_ctrl_o,
  output logic [3:0]  alu_op_o,
  input  logic [31:0] alu_res_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic [31:0] npc_o,
  output logic        jump_o
);
  localparam logic [3:0] ALU_ADD = 4'b0000;

  // operand-select keys
  localparam logic [1:0] SA_RS1  = 2'b00;
  localparam logic [1:0] SA_PC   = 2'b01;
  localparam logic [1:0] SA_ZERO = 2'b10;
  localparam logic [2:0] SB_RS2  = 3'b000;
  localparam logic [2:0] SB_IMM  = 3'b001;
  localparam logic [2:0] SB_FOUR = 3'b010;
  localparam logic [2:0] SB_SHMT = 3'b100;

  // instruction classes
  localparam logic [2:0] C_OP     = 3'b000;
  localparam logic [2:0] C_OPIMM  = 3'b001;
  localparam logic [2:0] C_SHIFT  = 3'b010;
  localparam logic [2:0] C_LUI    = 3'b011;
  localparam logic [2:0] C_AUIPC  = 3'b100;
  localparam logic [2:0] C_JAL    = 3'b101;
  localparam logic [2:0] C_JALR   = 3'b110;
  localparam logic [2:0] C_BRANCH = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EX1, S_EX2, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cls_q, cls_d;
  logic [3:0]  aluop_q, aluop_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_wen_q, rd_wen_d;
  logic [31:0] npc_q, npc_d;
  logic        jump_q, jump_d;

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_wen_o    = rd_wen_q;
  assign npc_o       = npc_q;
  assign jump_o      = jump_q;

  // ALU steering decoded from state and the latched class
  always_comb begin
    srca_ctrl_o = SA_RS1;
    srcb_ctrl_o = SB_RS2;
    alu_op_o    = ALU_ADD;
    if (state_q == S_EX1) begin
      case (cls_q)
        C_OP:     begin srca_ctrl_o = SA_RS1;  srcb_ctrl_o = SB_RS2;  alu_op_o = aluop_q; end
        C_OPIMM:  begin srca_ctrl_o = SA_RS1;  srcb_ctrl_o = SB_IMM;  alu_op_o = aluop_q; end
        C_SHIFT:  begin srca_ctrl_o = SA_RS1;  srcb_ctrl_o = SB_SHMT; alu_op_o = aluop_q; end
        C_LUI:    begin srca_ctrl_o = SA_ZERO; srcb_ctrl_o = SB_IMM;  alu_op_o = ALU_ADD; end
        C_AUIPC:  begin srca_ctrl_o = SA_PC;   srcb_ctrl_o = SB_IMM;  alu_op_o = ALU_ADD; end
        C_JAL,
        C_JALR:   begin srca_ctrl_o = SA_PC;   srcb_ctrl_o = SB_FOUR; alu_op_o = ALU_ADD; end
        default:  begin srca_ctrl_o = SA_RS1;  srcb_ctrl_o = SB_RS2;  alu_op_o = aluop_q; end
      endcase
    end else if (state_q == S_EX2) begin
      // second pass computes the redirect target; JALR is register-relative
      srca_ctrl_o = (cls_q == C_JALR) ? SA_RS1 : SA_PC;
      srcb_ctrl_o = SB_IMM;
      alu_op_o    = ALU_ADD;
    end
  end

  // next-state and result capture
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    aluop_d     = aluop_q;
    out_valid_d = out_valid_q;
    rd_data_d   = rd_data_q;
    rd_wen_d    = rd_wen_q;
    npc_d       = npc_q;
    jump_d      = jump_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          cls_d   = cls_i;
          aluop_d = aluop_i;
          state_d = S_EX1;
        end
      end
      S_EX1: begin
        npc_d  = '0;
        jump_d = 1'b0;
        if (cls_q == C_BRANCH) begin
          rd_data_d = '0;
          rd_wen_d  = 1'b0;
          if (alu_res_i[0]) begin
            state_d = S_EX2;
          end else begin
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end else begin
          // for JAL/JALR this is the link value pc+4
          rd_data_d = alu_res_i;
          rd_wen_d  = 1'b1;
          if (cls_q == C_JAL || cls_q == C_JALR) begin
            state_d = S_EX2;
          end else begin
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_EX2: begin
        npc_d       = (cls_q == C_JALR) ? {alu_res_i[31:1], 1'b0} : alu_res_i;
        jump_d      = 1'b1;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and registered outputs; reset discards any in-flight op
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cls_q       <= '0;
      aluop_q     <= '0;
      out_valid_q <= 1'b0;
      rd_data_q   <= '0;
      rd_wen_q    <= 1'b0;
      npc_q       <= '0;
      jump_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      aluop_q     <= aluop_d;
      out_valid_q <= out_valid_d;
      rd_data_q   <= rd_data_d;
      rd_wen_q    <= rd_wen_d;
      npc_q       <= npc_d;
      jump_q      <= jump_d;
    end
  end
endmodule

// File: tb/tb_ysyx_25040101_exu_seq.sv
// Bench for the execute sequencer: a behavioural ALU closes the loop,
// directed instructions push expectations, a negedge monitor checks them.
module tb_ysyx_25040101_exu_seq;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  cls_i;
  logic [3:0]  aluop_i;
  logic [1:0]  srca_ctrl_o;
  logic [2:0]  srcb_ctrl_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_res_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] rd_data_o;
  logic        rd_wen_o;
  logic [31:0] npc_o;
  logic        jump_o;

  ysyx_25040101_exu_seq dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .cls_i(cls_i), .aluop_i(aluop_i), .srca_ctrl_o(srca_ctrl_o), .srcb_ctrl_o(srcb_ctrl_o),
    .alu_op_o(alu_op_o), .alu_res_i(alu_res_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
    .npc_o(npc_o), .jump_o(jump_o)
  );

  always #5 clk_i = ~clk_i;

  // IDU-side operands and a simple ALU (ADD, SUB, SLL, EQ, NE)
  logic [31:0] rs1, rs2, imm, pc, a, b;
  always_comb begin
    a = 32'h0;
    case (srca_ctrl_o)
      2'b00: a = rs1;
      2'b01: a = pc;
      default: a = 32'h0;
    endcase
    b = 32'hdead_beef;
    case (srcb_ctrl_o)
      3'b000: b = rs2;
      3'b001: b = imm;
      3'b010: b = 32'd4;
      3'b100: b = {27'h0, rs2[4:0]};
      default: b = 32'hdead_beef;
    endcase
    alu_res_i = 32'hbad0_bad0;
    case (alu_op_o)
      4'd0: alu_res_i = a + b;
      4'd1: alu_res_i = a - b;
      4'd2: alu_res_i = (b > 32'd31) ? 32'h0 : (a << b[4:0]);
      4'd8: alu_res_i = {31'h0, a == b};
      4'd9: alu_res_i = {31'h0, a != b};
      default: alu_res_i = 32'hbad0_bad0;
    endcase
  end

  typedef struct packed {
    logic [2:0]  cls;
    logic [3:0]  op;
    logic [1:0]  a1;
    logic [2:0]  b1;
    logic [3:0]  o1;
    logic        has2;
    logic [1:0]  a2;
    logic [2:0]  b2;
    logic [31:0] rd;
    logic        wen;
    logic [31:0] npc;
    logic        jmp;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, acc_cyc = 0, last_hs = 0, ph = 0;
  bit   seen_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [2:0] cls, input logic [3:0] op,
                              input logic [1:0] a1, input logic [2:0] b1, input logic [3:0] o1,
                              input logic has2, input logic [1:0] a2, input logic [2:0] b2,
                              input logic [31:0] rd, input logic wen,
                              input logic [31:0] npc, input logic jmp);
    exp_t e;
    e.cls = cls; e.op = op; e.a1 = a1; e.b1 = b1; e.o1 = o1;
    e.has2 = has2; e.a2 = a2; e.b2 = b2;
    e.rd = rd; e.wen = wen; e.npc = npc; e.jmp = jmp;
    return e;
  endfunction

  // monitor: controls in EX1/EX2, latency, and results whenever out_valid is up
  always @(negedge clk_i) begin
    exp_t f;
    cyc++;
    f = '0;
    if (exp_q.size() > 0) f = exp_q[0];
    if (!rst_n_i) begin
      ph = 0;
      seen_valid = 0;
    end else begin
      if (ph == 1) begin
        chk("ex1_srca", 32'(srca_ctrl_o), 32'(f.a1));
        chk("ex1_srcb", 32'(srcb_ctrl_o), 32'(f.b1));
        chk("ex1_aluop", 32'(alu_op_o), 32'(f.o1));
        chk("ex1_in_ready", 32'(in_ready_o), 32'h0);
        ph = 2;
      end else if (ph == 2) begin
        if (f.has2) begin
          chk("ex2_srca", 32'(srca_ctrl_o), 32'(f.a2));
          chk("ex2_srcb", 32'(srcb_ctrl_o), 32'(f.b2));
          chk("ex2_aluop", 32'(alu_op_o), 32'h0);
          chk("ex2_out_valid", 32'(out_valid_o), 32'h0);
        end
        ph = 3;
      end
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          if (!seen_valid) begin
            seen_valid = 1;
            chk("latency", 32'(cyc - acc_cyc), f.has2 ? 32'd3 : 32'd2);
          end
          chk("rd_data", rd_data_o, f.rd);
          chk("rd_wen", 32'(rd_wen_o), 32'(f.wen));
          chk("jump", 32'(jump_o), 32'(f.jmp));
          if (f.jmp) chk("npc", npc_o, f.npc);
          chk("done_in_ready", 32'(in_ready_o), 32'h0);
          if (out_ready_i) begin
            void'(exp_q.pop_front());
            last_hs = cyc;
            seen_valid = 0;
            ph = 0;
          end
        end
      end
      if (in_valid_i && in_ready_o) begin
        acc_cyc = cyc;
        ph = 1;
        seen_valid = 0;
      end
    end
  end

  // present an instruction; called just after a rising edge
  task automatic issue(input exp_t e, input bit keep, input bit wait_done);
    bit ok;
    exp_q.push_back(e);
    cls_i = e.cls;
    aluop_i = e.op;
    in_valid_i = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (in_ready_o) begin ok = 1; break; end
    end
    if (!ok) begin n_chk++; $display("FAIL accept_timeout: got no accept expected accept"); end
    @(posedge clk_i); #1;
    if (!keep) in_valid_i = 1'b0;
    if (wait_done) begin
      ok = 0;
      for (int i = 0; i < 60; i++) begin
        if (exp_q.size() == 0) begin ok = 1; break; end
        @(negedge clk_i);
      end
      if (!ok) begin
        n_chk++;
        $display("FAIL done_timeout: got %0d pending expected 0", exp_q.size());
        exp_q.delete();
      end
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    bit ok;
    rst_n_i = 1'b0; in_valid_i = 1'b0; cls_i = '0; aluop_i = '0; out_ready_i = 1'b1;
    rs1 = '0; rs2 = '0; imm = '0; pc = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_rd_data", rd_data_o, 32'h0);
    chk("rst_rd_wen", 32'(rd_wen_o), 32'h0);
    chk("rst_npc", npc_o, 32'h0);
    chk("rst_jump", 32'(jump_o), 32'h0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready_o), 32'h1);
    @(posedge clk_i); #1;

    // ADDI: 0x0c + 4
    rs1 = 32'h0c; imm = 32'h4;
    issue(mk(3'b001, 4'd0, 2'b00, 3'b001, 4'd0, 0, 2'b00, 3'b000, 32'h10, 1, 32'h0, 0), 0, 1);
    // JALR: link pc+4, target (rs1+imm) & ~1
    pc = 32'h8000_0000; rs1 = 32'h8000_1230; imm = 32'h5;
    issue(mk(3'b110, 4'd0, 2'b01, 3'b010, 4'd0, 1, 2'b00, 3'b001, 32'h8000_0004, 1, 32'h8000_1234, 1), 0, 1);
    // BEQ not taken
    rs1 = 32'h1; rs2 = 32'h2;
    issue(mk(3'b111, 4'd8, 2'b00, 3'b000, 4'd8, 0, 2'b00, 3'b000, 32'h0, 0, 32'h0, 0), 0, 1);
    // BEQ taken: pc + imm
    rs1 = 32'h5; rs2 = 32'h5; pc = 32'h8000_00f0; imm = 32'h10;
    issue(mk(3'b111, 4'd8, 2'b00, 3'b000, 4'd8, 1, 2'b01, 3'b001, 32'h0, 0, 32'h8000_0100, 1), 0, 1);
    // SLL by rs2[4:0]=3 (full rs2 would shift everything out)
    rs1 = 32'h1; rs2 = 32'hffff_ffe3;
    issue(mk(3'b010, 4'd2, 2'b00, 3'b100, 4'd2, 0, 2'b00, 3'b000, 32'h8, 1, 32'h0, 0), 0, 1);
    // LUI ignores the supplied op and rs1
    rs1 = 32'h7; imm = 32'h1234_5000;
    issue(mk(3'b011, 4'd1, 2'b10, 3'b001, 4'd0, 0, 2'b00, 3'b000, 32'h1234_5000, 1, 32'h0, 0), 0, 1);
    // OP SUB
    rs1 = 32'd10; rs2 = 32'd3;
    issue(mk(3'b000, 4'd1, 2'b00, 3'b000, 4'd1, 0, 2'b00, 3'b000, 32'h7, 1, 32'h0, 0), 0, 1);
    // AUIPC
    pc = 32'h8000_0000; imm = 32'h1000;
    issue(mk(3'b100, 4'd1, 2'b01, 3'b001, 4'd0, 0, 2'b00, 3'b000, 32'h8000_1000, 1, 32'h0, 0), 0, 1);
    // JAL
    pc = 32'h8000_0010; imm = 32'h20;
    issue(mk(3'b101, 4'd0, 2'b01, 3'b010, 4'd0, 1, 2'b01, 3'b001, 32'h8000_0014, 1, 32'h8000_0030, 1), 0, 1);

    // backpressure: DONE held 5 cycles while the next ADDI waits on in_valid
    out_ready_i = 1'b0;
    rs1 = 32'h10; rs2 = 32'h20; imm = 32'h4;
    issue(mk(3'b000, 4'd0, 2'b00, 3'b000, 4'd0, 0, 2'b00, 3'b000, 32'h30, 1, 32'h0, 0), 1, 0);
    cls_i = 3'b001; aluop_i = 4'd0;
    exp_q.push_back(mk(3'b001, 4'd0, 2'b00, 3'b001, 4'd0, 0, 2'b00, 3'b000, 32'h14, 1, 32'h0, 0));
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (out_valid_o) begin ok = 1; break; end
    end
    if (!ok) begin n_chk++; $display("FAIL bp_valid_timeout: got 0 expected 1"); end
    repeat (5) @(negedge clk_i);
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (in_ready_o) begin ok = 1; break; end
    end
    if (!ok) begin n_chk++; $display("FAIL bp_accept_timeout: got 0 expected 1"); end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    chk("bp_accept_gap", 32'(acc_cyc - last_hs), 32'd1);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) begin ok = 1; break; end
      @(negedge clk_i);
    end
    if (!ok) begin n_chk++; $display("FAIL bp_done_timeout: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
    @(posedge clk_i); #1;

    // reset during EX2 of a JAL discards it
    pc = 32'h8000_0040; imm = 32'h100;
    issue(mk(3'b101, 4'd0, 2'b01, 3'b010, 4'd0, 1, 2'b01, 3'b001, 32'h8000_0044, 1, 32'h8000_0140, 1), 0, 0);
    @(posedge clk_i); #2;
    rst_n_i = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("mid_rst_jump", 32'(jump_o), 32'h0);
    chk("mid_rst_npc", npc_o, 32'h0);
    chk("mid_rst_rd_wen", 32'(rd_wen_o), 32'h0);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready_o), 32'h1);
    @(posedge clk_i); #1;
    rs1 = 32'h100; imm = 32'h23;
    issue(mk(3'b001, 4'd0, 2'b00, 3'b001, 4'd0, 0, 2'b00, 3'b000, 32'h123, 1, 32'h0, 0), 0, 1);

    repeat (2) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
